bus_generator_arbiter: RTL and testbench



---
 rtl/bus_pkg.sv | 35 +++
 rtl/bus_lane.sv | 128 ++++++++++++
 rtl/bus_generator_arbiter.sv | 47 ++++
 tb/tb_bus_generator_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the bus generator / arbiter.
//   ID_W         : width of the destination-ID field at the top of each packet
//   lane_state_e : per-lane FSM state (IDLE, POP, PUSH)
//   dest_hit     : decides whether one device receives a packet, given the
//                  packet's destination ID and the source device
package bus_pkg;

    localparam int ID_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_PUSH = 2'd2
    } lane_state_e;

    // Broadcast reaches every device except the source. A unicast ID inside
    // the device range reaches exactly that device, and that includes the
    // source itself. Any other ID reaches nobody, so the packet is dropped.
    function automatic logic dest_hit(
        input logic [ID_W-1:0] id,
        input logic [ID_W-1:0] src,
        input logic [ID_W-1:0] dev,
        input logic [ID_W:0]   n_dev,
        input logic [ID_W-1:0] bcast
    );
        if (id == bcast) begin
            dest_hit = (dev != src);
        end else if ({1'b0, id} < n_dev) begin
            dest_hit = (dev == id);
        end else begin
            dest_hit = 1'b0;
        end
    endfunction

endpackage

// File: rtl/bus_lane.sv
// One bus lane: round-robin arbiter, packet latch and destination decode.
// Ports:
//   clk, reset_i : clock and synchronous active-high reset
//   pndng_i      : per-device "source FIFO non-empty"
//   d_pop_i      : per-device head-of-FIFO packet
//   pop_o        : per-device dequeue strobe, a single-cycle pulse
//   push_o       : per-device enqueue strobe, a single-cycle pulse
//   d_push_o     : bus data, the same value on every device
//   state_o      : current FSM state, for observation
// Handshake: a FIFO may raise pndng_i at any time, and d_pop_i must be valid
// while pndng_i is high. pop_o is high for exactly one cycle, and the FIFO
// dequeues on the edge that ends that cycle. pndng_i is sampled again only
// after the push cycle.
module bus_lane
    import bus_pkg::*;
#(
    parameter int              drvrs     = 5,
    parameter int              pckg_sz   = 16,
    parameter logic [ID_W-1:0] broadcast = 8'hFF
) (
    input  logic                             clk,
    input  logic                             reset_i,
    input  logic [drvrs-1:0]                 pndng_i,
    input  logic [drvrs-1:0][pckg_sz-1:0]    d_pop_i,
    output logic [drvrs-1:0]                 pop_o,
    output logic [drvrs-1:0]                 push_o,
    output logic [drvrs-1:0][pckg_sz-1:0]    d_push_o,
    output lane_state_e                      state_o
);

    localparam int SW = $clog2(drvrs);
    localparam logic [SW-1:0] LAST_DEV = SW'(drvrs - 1);

    lane_state_e          state_q, state_d;
    logic [SW-1:0]        last_q, last_d;
    logic [SW-1:0]        src_q, src_d;
    logic [pckg_sz-1:0]   pkt_q, pkt_d;
    logic [pckg_sz-1:0]   dpush_q, dpush_d;
    logic [drvrs-1:0]     pop_q, pop_d;
    logic [drvrs-1:0]     push_q, push_d;

    logic                 gnt_vld;
    logic [SW-1:0]        gnt_idx;
    logic [SW-1:0]        cand;
    logic [drvrs-1:0]     hit;

    // Search starts at the device after the last grant and wraps around, so
    // a device cannot win twice while another device is waiting.
    always_comb begin : rr_pick
        gnt_vld = 1'b0;
        gnt_idx = last_q;
        cand    = last_q;
        for (int k = 0; k < drvrs; k++) begin
            cand = (cand == LAST_DEV) ? '0 : cand + 1'b1;
            if (!gnt_vld && pndng_i[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    for (genvar d = 0; d < drvrs; d++) begin : g_dec
        assign hit[d] = dest_hit(pkt_q[pckg_sz-1 -: ID_W], ID_W'(src_q),
                                 ID_W'(d), (ID_W+1)'(drvrs), broadcast);
        assign d_push_o[d] = dpush_q;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            last_q  <= LAST_DEV;
            src_q   <= '0;
            pkt_q   <= '0;
            dpush_q <= '0;
            pop_q   <= '0;
            push_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            src_q   <= src_d;
            pkt_q   <= pkt_d;
            dpush_q <= dpush_d;
            pop_q   <= pop_d;
            push_q  <= push_d;
        end
    end

    // Next state. PUSH arbitrates just like IDLE, which lets a new grant
    // follow a push with no gap.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_POP:  state_d = ST_PUSH;
            default: state_d = gnt_vld ? ST_POP : ST_IDLE;
        endcase
    end

    // Outputs and datapath. The strobes default to low, so each one is a
    // single-cycle pulse.
    always_comb begin
        pop_d   = '0;
        push_d  = '0;
        dpush_d = dpush_q;
        last_d  = last_q;
        src_d   = src_q;
        pkt_d   = pkt_q;
        case (state_q)
            ST_POP: begin
                dpush_d = pkt_q;
                push_d  = hit;
            end
            default: begin
                if (gnt_vld) begin
                    pop_d[gnt_idx] = 1'b1;
                    last_d         = gnt_idx;
                    src_d          = gnt_idx;
                    pkt_d          = d_pop_i[gnt_idx];
                end
            end
        endcase
    end

    assign pop_o   = pop_q;
    assign push_o  = push_q;
    assign state_o = state_q;

endmodule

// File: rtl/bus_generator_arbiter.sv
// Shared-bus emulator. It holds `bits` independent lanes, and each lane moves
// packets between `drvrs` FIFO-attached devices using round-robin
// arbitration. Broadcast is supported.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   pndng      : [bits][drvrs] source FIFO non-empty
//   D_pop      : [bits][drvrs] head-of-FIFO packet
//   pop        : [bits][drvrs] dequeue strobe
//   push       : [bits][drvrs] enqueue strobe
//   D_push     : [bits][drvrs] bus data, the same value across a lane
//   state_dbg  : [bits] lane FSM state, for observation
module bus_generator_arbiter
    import bus_pkg::*;
#(
    parameter int              bits      = 1,
    parameter int              drvrs     = 5,
    parameter int              pckg_sz   = 16,
    parameter logic [ID_W-1:0] broadcast = 8'hFF
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [bits-1:0][drvrs-1:0]                 pndng,
    input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]    D_pop,
    output logic [bits-1:0][drvrs-1:0]                 pop,
    output logic [bits-1:0][drvrs-1:0]                 push,
    output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]    D_push,
    output lane_state_e [bits-1:0]                     state_dbg
);

    for (genvar b = 0; b < bits; b++) begin : g_lane
        bus_lane #(
            .drvrs     (drvrs),
            .pckg_sz   (pckg_sz),
            .broadcast (broadcast)
        ) u_lane (
            .clk      (clk),
            .reset_i  (reset),
            .pndng_i  (pndng[b]),
            .d_pop_i  (D_pop[b]),
            .pop_o    (pop[b]),
            .push_o   (push[b]),
            .d_push_o (D_push[b]),
            .state_o  (state_dbg[b])
        );
    end

endmodule

// File: tb/tb_bus_generator_arbiter.sv
module tb_bus_generator_arbiter;
  import bus_pkg::*;

  localparam int N = 5;
  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [0:0][N-1:0]        pndng;
  logic [0:0][N-1:0][W-1:0] D_pop;
  logic [0:0][N-1:0]        pop;
  logic [0:0][N-1:0]        push;
  logic [0:0][N-1:0][W-1:0] D_push;
  lane_state_e [0:0]        state_dbg;

  bus_generator_arbiter #(
    .bits(1), .drvrs(N), .pckg_sz(W), .broadcast(8'hFF)
  ) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop),
    .pop(pop), .push(push), .D_push(D_push), .state_dbg(state_dbg)
  );

  // ---------------- FIFO models and reference model ----------------
  logic [W-1:0] fifo_q [N][$];
  int           m_last;
  bit           m_busy;
  logic [W-1:0] m_pkt;
  int           m_src;
  logic [N-1:0] exp_pop;
  logic [N-1:0] exp_push;
  logic [W-1:0] exp_dpush;

  int n_cmp  = 0;
  int n_fail = 0;

  // observations used by the directed checks
  logic [N-1:0] seen_push_mask;
  logic [W-1:0] seen_dpush;
  int           n_push_ev;
  int           n_pop_ev;
  bit           rec_order;
  logic [7:0]   exp_q[$];
  logic [7:0]   obs_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Destination set derived from the packet rules.
  function automatic logic [N-1:0] dest_mask(input logic [W-1:0] pkt, input int src);
    int id;
    id = int'(pkt[W-1 -: 8]);
    if (id == 255) dest_mask = N'((1 << N) - 1) & ~N'(1 << src);
    else if (id < N) dest_mask = N'(1 << id);
    else dest_mask = '0;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      pndng[0][i] = (fifo_q[i].size() != 0);
      D_pop[0][i] = (fifo_q[i].size() != 0) ? fifo_q[i][0] : W'($urandom);
    end
  endtask

  // Predicts the outputs after the coming rising edge.
  task automatic model_step();
    bit found;
    int c;
    if (reset) begin
      exp_pop = '0; exp_push = '0; exp_dpush = '0;
      m_last = N - 1; m_busy = 0;
    end else if (m_busy) begin
      exp_pop   = '0;
      exp_dpush = m_pkt;
      exp_push  = dest_mask(m_pkt, m_src);
      m_busy    = 0;
    end else begin
      exp_pop  = '0;
      exp_push = '0;
      found    = 0;
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (!found && pndng[0][c]) begin
          found      = 1;
          exp_pop[c] = 1'b1;
          m_pkt      = D_pop[0][c];
          m_src      = c;
          m_last     = c;
          m_busy     = 1;
        end
      end
    end
  endtask

  // ---------------- driver: one clock step ----------------
  task automatic step();
    // the source FIFO dequeues on the edge that ends its pop cycle
    for (int i = 0; i < N; i++)
      if (exp_pop[i] && fifo_q[i].size() != 0) void'(fifo_q[i].pop_front());
    drive_inputs();
    model_step();
    @(negedge clk);
    check("pop", 32'(pop[0]), 32'(exp_pop));
    check("push", 32'(push[0]), 32'(exp_push));
    for (int i = 0; i < N; i++) check("d_push", 32'(D_push[0][i]), 32'(exp_dpush));
    if (push[0] != '0) begin
      seen_push_mask = push[0];
      seen_dpush     = D_push[0][0];
      n_push_ev++;
    end
    if (pop[0] != '0) begin
      n_pop_ev++;
      if (rec_order)
        for (int i = 0; i < N; i++) if (pop[0][i]) obs_q.push_back(8'(i));
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_obs();
    n_push_ev = 0; n_pop_ev = 0; seen_push_mask = '0; seen_dpush = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  sel;
    int  dev;
    bit  got;
    logic [7:0] id;
    exp_pop = '0; exp_push = '0; exp_dpush = '0;
    m_last = N - 1; m_busy = 0; rec_order = 0;
    clear_obs();

    // Reset held two cycles with packets pending.
    reset = 1'b1;
    fifo_q[0].push_back(16'h0222);
    fifo_q[4].push_back(16'h0100);
    run(2);
    check("reset_state", 32'(state_dbg[0]), 32'(ST_IDLE));
    check("reset_pop", 32'(pop[0]), 32'h0);
    reset = 1'b0;
    rec_order = 1; obs_q.delete();
    run(10);
    rec_order = 0;
    check("post_reset_first", 32'(obs_q.size() > 0 ? obs_q[0] : 8'hEE), 32'h0);

    // Unicast from device 1 to device 3.
    clear_obs();
    fifo_q[1].push_back(16'h03AB);
    run(6);
    check("uni_pops", n_pop_ev, 1);
    check("uni_pushes", n_push_ev, 1);
    check("uni_mask", 32'(seen_push_mask), 32'b01000);
    check("uni_data", 32'(seen_dpush), 32'h03AB);

    // Broadcast from device 2.
    clear_obs();
    fifo_q[2].push_back(16'hFF55);
    run(6);
    check("bc_mask", 32'(seen_push_mask), 32'b11011);
    check("bc_data", 32'(seen_dpush), 32'hFF55);

    // Round-robin from a fresh reset.
    reset = 1'b1;
    run(2);
    reset = 1'b0;
    for (int i = 0; i < N; i++) fifo_q[i].push_back({8'((i + 1) % N), 8'(8'h10 + i)});
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back(8'(i));
    rec_order = 1; obs_q.delete();
    run(14);
    rec_order = 0;
    check("rr_count", obs_q.size(), exp_q.size());
    for (int k = 0; k < N; k++)
      check("rr_order", 32'(k < obs_q.size() ? obs_q[k] : 8'hEE), 32'(exp_q[k]));

    // Invalid destination is dropped.
    clear_obs();
    fifo_q[0].push_back(16'h0712);
    run(6);
    check("inv_pops", n_pop_ev, 1);
    check("inv_pushes", n_push_ev, 0);
    check("inv_state", 32'(state_dbg[0]), 32'(ST_IDLE));

    // Reset while a push is high.
    fifo_q[1].push_back(16'h0200);
    fifo_q[3].push_back(16'h0400);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (exp_push != '0) got = 1;
    end
    check("push_seen_before_reset", 32'(got), 32'h1);
    reset = 1'b1;
    step();
    check("rst_push_low", 32'(push[0]), 32'h0);
    check("rst_pop_low", 32'(pop[0]), 32'h0);
    reset = 1'b0;
    run(8);

    // Random traffic with occasional resets.
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        dev = $urandom_range(0, N - 1);
        if (fifo_q[dev].size() < 4) begin
          sel = $urandom_range(0, 3);
          if (sel == 0) id = 8'hFF;
          else if (sel == 1) id = 8'($urandom_range(N, 254));
          else id = 8'($urandom_range(0, N - 1));
          fifo_q[dev].push_back({id, 8'($urandom)});
        end
      end
      reset = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0;
    run(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
